// File: rtl/rx_gate_pkg.sv
// rtl/rx_gate_pkg.sv - shared state encoding, status-vector field positions and helpers
package rx_gate_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    WAIT_STAT = 2'd2,
    DROP      = 2'd3
  } gate_state_e;

  localparam int          STAT_OK_BIT  = 0;
  localparam int          STAT_LEN_MSB = 21;
  localparam int          STAT_LEN_LSB = 6;
  localparam logic [15:0] FCS_LEN      = 16'd4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gate_byte_ram.sv
// rtl/gate_byte_ram.sv - simple dual-port byte RAM, synchronous write and registered read
module gate_byte_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);

  logic [7:0] r_mem [1 << ADDR_W];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read-before-write on a shared address; the caller bypasses that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= 8'd0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterised show-ahead synchronous FIFO
module sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

  logic [WIDTH-1:0]    r_mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_empty;
  logic                w_do_push;
  logic                w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = ((r_wr_ptr - r_rd_ptr) == FULL_CNT);
  assign o_valid   = !w_empty;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !w_empty;
  assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2 + 1)'(w_do_push);
      r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2 + 1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/rx_frame_gate.sv
// rtl/rx_frame_gate.sv - store-and-forward gate releasing only frames with good MAC status
module rx_frame_gate
  import rx_gate_pkg::*;
#(
  parameter int DEPTH_LOG2     = 11,
  parameter int LEN_DEPTH_LOG2 = 3,
  parameter int WARN_LEVEL     = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [26:0] stat_vector,
  input  logic        stat_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] len_data,
  output logic        len_valid,
  input  logic        len_ready,
  output logic        full_warn,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_drop
);

  localparam int             PW        = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0]  RAM_BYTES = PW'(1 << DEPTH_LOG2);
  localparam logic [PW-1:0]  PTR_ONE   = PW'(1);

  gate_state_e         r_state;
  gate_state_e         w_state_nxt;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_cmt_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [15:0]         r_byte_cnt;
  logic                r_bad;
  logic [15:0]         r_cnt_ok;
  logic [15:0]         r_cnt_drop;
  logic                r_full_warn;
  logic                r_byp;
  logic [7:0]          r_byp_data;

  logic [15:0]         w_stat_len;
  logic [15:0]         w_pay_len;
  logic                w_last_byte;
  logic                w_full_wr;
  logic                w_full_cmt;
  logic                w_room_full;
  logic                w_eval;
  logic [15:0]         w_cnt_eval;
  logic                w_bad_eval;
  logic                w_lq_full;
  logic                w_good;
  logic                w_pop;
  logic [PW-1:0]       w_rd_next;
  logic [PW-1:0]       w_free;
  logic [7:0]          w_ram_q;
  logic                w_unused;

  logic                w_wr_en;
  logic [PW-1:0]       w_wr_at;
  logic [PW-1:0]       w_wr_ptr_nxt;
  logic [PW-1:0]       w_cmt_ptr_nxt;
  logic [15:0]         w_byte_cnt_nxt;
  logic                w_bad_nxt;
  logic                w_lq_push;
  logic                w_ok_inc;
  logic                w_drop_inc;

  assign w_unused    = ^{stat_vector[26:22], stat_vector[5:1]};
  assign w_stat_len  = stat_vector[STAT_LEN_MSB:STAT_LEN_LSB];
  assign w_pay_len   = w_stat_len - FCS_LEN;
  assign w_last_byte = in_valid && in_last;
  assign w_full_wr   = ((r_wr_ptr - r_rd_ptr) == RAM_BYTES);
  assign w_full_cmt  = ((r_cmt_ptr - r_rd_ptr) == RAM_BYTES);
  assign w_free      = RAM_BYTES - (r_wr_ptr - r_rd_ptr);

  // A status pulse closes the pending frame; outside WAIT_STAT it only counts alongside in_last.
  assign w_eval      = stat_valid && ((r_state == WAIT_STAT) || w_last_byte);
  assign w_cnt_eval  = (r_state == IDLE) ? 16'd1 :
                       (r_state == RECV) ? sat_inc16(r_byte_cnt) : r_byte_cnt;
  assign w_bad_eval  = (r_state == DROP) ||
                       ((r_state == IDLE) && w_full_wr) ||
                       ((r_state == RECV) && (r_bad || w_full_wr)) ||
                       ((r_state == WAIT_STAT) && r_bad);
  assign w_good      = w_eval && stat_vector[STAT_OK_BIT] && !w_bad_eval &&
                       (w_stat_len >= FCS_LEN) && (w_cnt_eval == w_pay_len) && !w_lq_full;
  // A byte arriving in WAIT_STAT lands at cmt_ptr unless the pending frame commits this cycle.
  assign w_room_full = ((r_state == WAIT_STAT) && !w_good) ? w_full_cmt : w_full_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, RECV: begin
        if (in_valid) begin
          if (in_last)          w_state_nxt = stat_valid ? IDLE : WAIT_STAT;
          else if (w_room_full) w_state_nxt = DROP;
          else                  w_state_nxt = RECV;
        end
      end
      DROP: begin
        if (w_last_byte) w_state_nxt = stat_valid ? IDLE : WAIT_STAT;
      end
      WAIT_STAT: begin
        if (in_valid) begin
          if (in_last)          w_state_nxt = WAIT_STAT;
          else if (w_room_full) w_state_nxt = DROP;
          else                  w_state_nxt = RECV;
        end else if (stat_valid) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wr_en        = 1'b0;
    w_wr_at        = r_wr_ptr;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_cmt_ptr_nxt  = r_cmt_ptr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_bad_nxt      = r_bad;
    w_lq_push      = 1'b0;
    w_ok_inc       = 1'b0;
    w_drop_inc     = 1'b0;
    case (r_state)
      IDLE, RECV: begin
        if (in_valid) begin
          w_wr_en        = !w_room_full;
          w_wr_ptr_nxt   = w_room_full ? r_wr_ptr : r_wr_ptr + PTR_ONE;
          w_byte_cnt_nxt = w_cnt_eval;
          w_bad_nxt      = w_bad_eval;
          if (w_good) begin
            w_cmt_ptr_nxt = w_wr_ptr_nxt;
            w_lq_push     = 1'b1;
            w_ok_inc      = 1'b1;
          end else if (w_eval) begin
            w_wr_ptr_nxt  = r_cmt_ptr;
            w_drop_inc    = 1'b1;
          end
        end
      end
      DROP: begin
        if (w_eval) begin
          w_wr_ptr_nxt = r_cmt_ptr;
          w_drop_inc   = 1'b1;
        end
      end
      WAIT_STAT: begin
        if (w_good) begin
          w_cmt_ptr_nxt = r_wr_ptr;
          w_lq_push     = 1'b1;
          w_ok_inc      = 1'b1;
        end else if (w_eval || in_valid) begin
          w_wr_at       = r_cmt_ptr;
          w_drop_inc    = 1'b1;
        end
        w_wr_ptr_nxt = w_wr_at;
        if (in_valid) begin
          w_wr_en        = !w_room_full;
          w_wr_ptr_nxt   = w_room_full ? w_wr_at : w_wr_at + PTR_ONE;
          w_byte_cnt_nxt = 16'd1;
          w_bad_nxt      = w_room_full;
        end
      end
      default: ;
    endcase
  end

  assign out_valid = (r_cmt_ptr != r_rd_ptr);
  assign w_pop     = out_valid && out_ready;
  assign w_rd_next = r_rd_ptr + PW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_cmt_ptr   <= '0;
      r_rd_ptr    <= '0;
      r_byte_cnt  <= 16'd0;
      r_bad       <= 1'b0;
      r_cnt_ok    <= 16'd0;
      r_cnt_drop  <= 16'd0;
      r_full_warn <= 1'b0;
      r_byp       <= 1'b0;
      r_byp_data  <= 8'd0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_cmt_ptr   <= w_cmt_ptr_nxt;
      r_rd_ptr    <= w_rd_next;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_bad       <= w_bad_nxt;
      r_full_warn <= (int'(w_free) < WARN_LEVEL);
      if (w_ok_inc)   r_cnt_ok   <= sat_inc16(r_cnt_ok);
      if (w_drop_inc) r_cnt_drop <= sat_inc16(r_cnt_drop);
      // Prefetch register: holds a byte written to the address being read on the same edge.
      r_byp       <= w_wr_en && (w_wr_at[DEPTH_LOG2-1:0] == w_rd_next[DEPTH_LOG2-1:0]);
      r_byp_data  <= in_data;
    end
  end

  gate_byte_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_at[DEPTH_LOG2-1:0]),
    .i_wr_data (in_data),
    .i_rd_addr (w_rd_next[DEPTH_LOG2-1:0]),
    .o_rd_data (w_ram_q)
  );

  sync_fifo #(
    .WIDTH      (16),
    .DEPTH_LOG2 (LEN_DEPTH_LOG2)
  ) u_len_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_lq_push),
    .i_data  (w_pay_len),
    .i_pop   (len_ready),
    .o_data  (len_data),
    .o_valid (len_valid),
    .o_full  (w_lq_full)
  );

  assign out_data  = out_valid ? (r_byp ? r_byp_data : w_ram_q) : 8'd0;
  assign full_warn = r_full_warn;
  assign cnt_ok    = r_cnt_ok;
  assign cnt_drop  = r_cnt_drop;

endmodule

// File: tb/tb_rx_frame_gate.sv
// tb/tb_rx_frame_gate.sv - scoreboard bench for rx_frame_gate on a 64-byte RAM, 2-entry length queue
module tb_rx_frame_gate;

  localparam int DL = 6;
  localparam int LL = 1;
  localparam int WL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [26:0] stat_vector = '0;
  logic        stat_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] len_data;
  logic        len_valid;
  logic        len_ready = 1'b1;
  logic        full_warn;
  logic [15:0] cnt_ok;
  logic [15:0] cnt_drop;

  always #5 clk = ~clk;

  rx_frame_gate #(
    .DEPTH_LOG2     (DL),
    .LEN_DEPTH_LOG2 (LL),
    .WARN_LEVEL     (WL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .stat_vector (stat_vector),
    .stat_valid  (stat_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .len_data    (len_data),
    .len_valid   (len_valid),
    .len_ready   (len_ready),
    .full_warn   (full_warn),
    .cnt_ok      (cnt_ok),
    .cnt_drop    (cnt_drop)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_ok   = 0;
  int          exp_drop = 0;
  logic [7:0]  exp_bytes [$];
  logic [15:0] exp_lens  [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_bytes.size() == 0) check_eq("spurious_byte", exp_bytes.size(), 1);
      else                       check_eq("out_data", out_data, exp_bytes.pop_front());
    end
    if (rst_n && len_valid && len_ready) begin
      if (exp_lens.size() == 0) check_eq("spurious_len", exp_lens.size(), 1);
      else                      check_eq("len_data", len_data, exp_lens.pop_front());
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  function automatic logic [26:0] mk_stat(input logic ok, input logic [15:0] len);
    return {5'd0, len, 5'd0, ok};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic last, input logic sv, input logic [26:0] vec);
    in_valid = 1'b1; in_data = d; in_last = last; stat_valid = sv; stat_vector = vec;
    tick();
    in_valid = 1'b0; in_last = 1'b0; stat_valid = 1'b0; stat_vector = '0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] base, input logic last, input logic good);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = base + 8'(i);
      if (good) exp_bytes.push_back(b);
      drive(b, last && (i == n - 1), 1'b0, '0);
    end
  endtask

  task automatic send_stat(input logic ok, input logic [15:0] len);
    stat_valid = 1'b1; stat_vector = mk_stat(ok, len);
    tick();
    stat_valid = 1'b0; stat_vector = '0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && (exp_bytes.size() != 0 || exp_lens.size() != 0); i++) tick();
    check_eq(tag, exp_bytes.size() + exp_lens.size(), 0);
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_cnt_ok"}, cnt_ok, exp_ok);
    check_eq({tag, "_cnt_drop"}, cnt_drop, exp_drop);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_len_valid"}, len_valid, 0);
    check_eq({tag, "_full_warn"}, full_warn, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_len_data"}, len_data, 0);
    check_eq({tag, "_cnt_ok"}, cnt_ok, 0);
    check_eq({tag, "_cnt_drop"}, cnt_drop, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(); tick();

    // Good 64-byte frame fills the RAM exactly
    send_bytes(64, 8'h00, 1'b1, 1'b1);
    check_eq("t1_pre_commit_valid", out_valid, 0);
    exp_lens.push_back(16'd64); exp_ok++;
    send_stat(1'b1, 16'd68);
    check_eq("t1_commit_visible", out_valid, 1);
    check_eq("t1_len_visible", len_valid, 1);
    check_eq("t1_len_value", len_data, 64);
    wait_drain("t1_drain");
    check_counters("t1");

    // Bad status rolls back, then a good 10-byte frame
    send_bytes(64, 8'h40, 1'b1, 1'b0);
    send_stat(1'b0, 16'd68); exp_drop++;
    check_eq("t2_warn_full", full_warn, 1);
    tick();
    check_eq("t2_warn_after_rollback", full_warn, 0);
    check_eq("t2_no_out", out_valid, 0);
    send_bytes(10, 8'hA0, 1'b1, 1'b1);
    exp_lens.push_back(16'd10); exp_ok++;
    send_stat(1'b1, 16'd14);
    wait_drain("t2_drain");
    check_counters("t2");

    // Length mismatch
    send_bytes(60, 8'h10, 1'b1, 1'b0);
    send_stat(1'b1, 16'd68); exp_drop++;
    tick();
    check_eq("t3_len_valid", len_valid, 0);
    check_eq("t3_out_valid", out_valid, 0);
    check_counters("t3");

    // Single-byte frame with status on the last byte, then a 5-byte one
    exp_bytes.push_back(8'h5A); exp_lens.push_back(16'd1); exp_ok++;
    drive(8'h5A, 1'b1, 1'b1, mk_stat(1'b1, 16'd5));
    check_eq("t7_one_byte_valid", out_valid, 1);
    check_eq("t7_one_byte_data", out_data, 8'h5A);
    send_bytes(4, 8'h30, 1'b0, 1'b1);
    exp_bytes.push_back(8'h34); exp_lens.push_back(16'd5); exp_ok++;
    drive(8'h34, 1'b1, 1'b1, mk_stat(1'b1, 16'd9));
    wait_drain("t7_drain");
    check_counters("t7");

    // New frame starts before the status of the previous one
    send_bytes(6, 8'h60, 1'b1, 1'b0);
    send_bytes(4, 8'h70, 1'b1, 1'b1); exp_drop++;
    exp_lens.push_back(16'd4); exp_ok++;
    send_stat(1'b1, 16'd8);
    wait_drain("t8_drain");
    check_counters("t8");

    // Overflow of a 100-byte frame with no downstream pops
    out_ready = 1'b0;
    send_bytes(40, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    check_eq("t4_warn_free24", full_warn, 0);
    send_bytes(10, 8'h28, 1'b0, 1'b0);
    tick(); tick();
    check_eq("t4_warn_free14", full_warn, 1);
    send_bytes(50, 8'h32, 1'b1, 1'b0);
    send_stat(1'b1, 16'd104); exp_drop++;
    check_eq("t4_no_out", out_valid, 0);
    tick(); tick();
    check_eq("t4_warn_released", full_warn, 0);
    out_ready = 1'b1;
    tick(); tick();
    check_counters("t4");

    // Length queue full drops the third frame
    len_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_bytes(8, 8'h80 + 8'(8 * k), 1'b1, k < 2);
      send_stat(1'b1, 16'd12);
      if (k < 2) begin exp_lens.push_back(16'd8); exp_ok++; end
      else       exp_drop++;
    end
    check_eq("t5_len_valid", len_valid, 1);
    check_eq("t5_len_head", len_data, 8);
    len_ready = 1'b1;
    wait_drain("t5_drain");
    check_counters("t5");

    // Reset in the middle of a frame with committed data pending
    out_ready = 1'b0; len_ready = 1'b0;
    send_bytes(30, 8'hC0, 1'b1, 1'b0);
    send_stat(1'b1, 16'd34);
    send_bytes(20, 8'h00, 1'b0, 1'b0);
    tick();
    check_eq("t6_pre_out_valid", out_valid, 1);
    check_eq("t6_pre_full_warn", full_warn, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
    exp_bytes.delete(); exp_lens.delete();
    exp_ok = 0; exp_drop = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1; len_ready = 1'b1;
    send_bytes(16, 8'hD0, 1'b1, 1'b1);
    exp_lens.push_back(16'd16); exp_ok++;
    send_stat(1'b1, 16'd20);
    wait_drain("t6_drain");
    check_counters("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
